rr_mux_n: RTL and testbench
===========================

RR_MUX_N -- requirements
Module: rr_mux_n

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel (>=1).
REQ-002 Parameter NCH, default 4, number of input channels (>=2).
REQ-003 Derived SELW = max(1, clog2(NCH)); this is not a user parameter.
REQ-004 clk  input  1  single clock for all state; everything is rising-edge triggered.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 mode  input  1  0 = fixed select via sel; 1 = round-robin over valid channels.
REQ-007 sel  input  SELW  channel index, used only when mode=0.
REQ-008 in_data  input  NCH*WIDTH  flat bus; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 in_valid  input  NCH  per-channel valid.
REQ-010 in_ready  output  NCH  per-channel ready; at most one bit high per cycle.
REQ-011 out_data  output  WIDTH  registered data of the held item.
REQ-012 out_ch  output  SELW  registered source channel of the held item.
REQ-013 out_valid  output  1  output register holds an item.
REQ-014 out_ready  input  1  downstream accepts the item.

Function
REQ-015 The block SHALL have a one-entry output register: load_en = !out_valid || out_ready.
REQ-016 Fixed mode grant: channel sel is granted when in_valid[sel]=1; sel>=NCH SHALL grant nothing.
REQ-017 Round-robin grant: search starts at (ptr+1) mod NCH and wraps; the first channel with in_valid=1 is granted.
REQ-018 If no channel qualifies, there is no grant.
REQ-019 in_ready[g] SHALL equal load_en AND (g granted); it is combinational, and all other bits are 0.
REQ-020 Transfer on channel g means in_valid[g] && in_ready[g].
REQ-021 On a transfer: out_data <= in_data[g] and out_ch <= g at the next edge, and out_valid <= 1.
REQ-022 Latency from input transfer to out_valid is exactly 1 cycle.
REQ-023 With out_valid && out_ready and no transfer, out_valid SHALL clear at the next edge.
REQ-024 Simultaneous output pop and input transfer SHALL replace the item with no bubble, giving full throughput.
REQ-025 While out_valid && !out_ready: out_data, out_ch and out_valid SHALL hold, and all in_ready bits are 0.
REQ-026 ptr (SELW bits) SHALL update to g on every transfer in either mode, and holds otherwise.
REQ-027 Mode or sel changes SHALL take effect in the same cycle (combinational grant), never on the held item.
REQ-028 Round-robin wrap: after a grant to NCH-1, the search SHALL restart at channel 0.
REQ-029 Round-robin fairness: with all channels continuously valid and out_ready=1, the grant order is 0,1,...,NCH-1,0,...
REQ-030 The RTL SHALL be fully parametric, with no hard-coded 4-channel logic.

Reset
REQ-031 rst_n low SHALL asynchronously set out_valid=0, out_data=0, out_ch=0 and ptr=NCH-1, so that the first round-robin search starts at channel 0.
REQ-032 While rst_n is low, in_ready SHALL be all 0.
REQ-033 Reset mid-operation SHALL discard any held item; no output transfer completes in that cycle.
REQ-034 Release SHALL be synchronous-safe: the first transfer is possible on the first rising edge after rst_n goes high.

Verification (WIDTH=8, NCH=4)
REQ-035 Fixed select: mode=0, in_data={8'h33,8'h22,8'h11,8'h00}, all valid, out_ready=1, sel=0..3 on successive cycles -> out_data 00,11,22,33 and out_ch 0..3, each one cycle after its sel.
REQ-036 Round-robin: mode=1, all valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3; in_ready one-hot every cycle.
REQ-037 Round-robin skip: mode=1, in_valid=4'b1010 -> out_ch alternates 1,3,1,3; channels 0 and 2 never get in_ready.
REQ-038 Backpressure: item 8'hA5 held, out_ready=0 for 3 cycles -> out_data=A5 and out_valid=1 stable, in_ready=0; first cycle with out_ready=1 -> next item loaded with no bubble.
REQ-039 Invalid select: mode=0, sel=2, in_valid[2]=0 -> no grant, out_valid drops after the pending pop, and ptr is unchanged.
REQ-040 Reset mid-stream: rst_n pulsed low between edges while out_valid=1 -> out_valid=0 immediately; after release, round-robin restarts at channel 0.

Source files
------------

// File: rtl/rr_mux_n_if.sv
// rr_mux_n_if: input channel bundle and registered output handshake of rr_mux_n.
interface rr_mux_n_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;
    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/rr_mux_n.sv
// rr_mux_n: NCH-to-1 mux with fixed or round-robin grant into a one-entry output register.
module rr_mux_n #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input logic       clk,
    input logic       rst_n,
    rr_mux_n_if.slave b
);
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;
    logic [SELW-1:0]  ptr_q, ptr_d, ch_q, ch_d, rr_g, gnt;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d, rr_v, fx_v, gnt_v, load_en, xfer;
    // Scan downwards so the channel nearest after ptr_q is the last (winning) assignment.
    always_comb begin
        rr_v = 1'b0;
        rr_g = '0;
        for (int i = NCH; i >= 1; i--) begin
            if (b.in_valid[(int'(ptr_q) + i) % NCH]) begin
                rr_v = 1'b1;
                rr_g = SELW'((int'(ptr_q) + i) % NCH);
            end
        end
    end
    assign fx_v    = (int'(b.sel) < NCH) && b.in_valid[b.sel];
    assign gnt_v   = b.mode ? rr_v : fx_v;
    assign gnt     = b.mode ? rr_g : b.sel;
    assign load_en = !valid_q || b.out_ready;
    assign xfer    = rst_n && load_en && gnt_v;
    assign b.in_ready = xfer ? (NCH'(1) << gnt) : '0;
    always_comb begin
        ptr_d   = xfer ? gnt : ptr_q;
        ch_d    = xfer ? gnt : ch_q;
        data_d  = xfer ? b.in_data[gnt*WIDTH +: WIDTH] : data_q;
        valid_d = xfer || (valid_q && !b.out_ready);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= SELW'(NCH - 1);
            ch_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
    assign b.out_data  = data_q;
    assign b.out_ch    = ch_q;
    assign b.out_valid = valid_q;
endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: scoreboard bench for rr_mux_n (WIDTH=8, NCH=4) with a reference grant model.
module tb_rr_mux_n;
    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    logic clk = 1'b0;
    logic rst_n;
    int n_cmp = 0;
    int n_err = 0;
    int mptr;
    bit m_valid;
    logic [9:0] sb[$];
    rr_mux_n_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();
    rr_mux_n #(.WIDTH(WIDTH), .NCH(NCH)) dut (.clk(clk), .rst_n(rst_n), .b(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Sampled at negedge: predict grant from the model pointer, check, then advance the model.
    task automatic observe();
        int g = 0;
        bit gv = 0;
        bit ld;
        logic [9:0] e;
        if (bus.mode) begin
            for (int k = 1; k <= NCH; k++) begin
                int c = (mptr + k) % NCH;
                if (!gv && bus.in_valid[c]) begin
                    gv = 1;
                    g = c;
                end
            end
        end else if (int'(bus.sel) < NCH && bus.in_valid[bus.sel]) begin
            gv = 1;
            g = int'(bus.sel);
        end
        ld = !m_valid || bus.out_ready;
        chk("in_ready", 32'(bus.in_ready), (gv && ld) ? 32'(1) << g : 32'(0));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid && bus.out_ready) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_data", 32'(bus.out_data), 32'(e[7:0]));
                chk("out_ch", 32'(bus.out_ch), 32'(e[9:8]));
            end
        end
        if (gv && ld) begin
            sb.push_back({2'(g), bus.in_data[g*WIDTH +: WIDTH]});
            mptr = g;
            m_valid = 1;
        end else if (bus.out_ready) begin
            m_valid = 0;
        end
    endtask
    task automatic cyc();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst_n = 1'b0;
        bus.mode = 1'b0;
        bus.sel = '0;
        bus.in_data = '0;
        bus.in_valid = '1;
        bus.out_ready = 1'b1;
        mptr = NCH - 1;
        m_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_out_data", 32'(bus.out_data), 32'(0));
        chk("rst_out_ch", 32'(bus.out_ch), 32'(0));
        rst_n = 1'b1;
        bus.in_data = 32'h33221100;
        for (int s = 0; s < NCH; s++) begin
            bus.sel = 2'(s);
            cyc();
        end
        bus.mode = 1'b1;
        repeat (8) cyc();
        bus.in_valid = 4'b1010;
        repeat (5) cyc();
        bus.mode = 1'b0;
        bus.sel = '0;
        bus.in_valid = 4'b0001;
        bus.in_data = 32'h000000A5;
        cyc();
        bus.out_ready = 1'b0;
        bus.in_data = 32'h0000005A;
        repeat (3) begin
            cyc();
            chk("bp_data", 32'(bus.out_data), 32'hA5);
            chk("bp_in_ready", 32'(bus.in_ready), 32'(0));
        end
        bus.out_ready = 1'b1;
        repeat (2) cyc();
        bus.in_valid = 4'b1011;
        bus.sel = 2'd2;
        repeat (3) cyc();
        bus.mode = 1'b1;
        bus.in_valid = '1;
        bus.in_data = 32'hDDCCBBAA;
        repeat (4) cyc();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("arst_in_ready", 32'(bus.in_ready), 32'(0));
        m_valid = 0;
        mptr = NCH - 1;
        sb.delete();
        #1 rst_n = 1'b1;
        repeat (6) cyc();
        bus.in_valid = '0;
        repeat (3) cyc();
        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
